// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the two-stage EX -> WB datapath.
//   alu_op_t    4-bit ALU opcode type
//   OP_*        opcode encodings
//   IR_*        instruction-word field positions
package datapath_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'b0000;
  localparam alu_op_t OP_SUB  = 4'b0001;
  localparam alu_op_t OP_AND  = 4'b1000;
  localparam alu_op_t OP_OR   = 4'b1001;
  localparam alu_op_t OP_XOR  = 4'b1010;
  localparam alu_op_t OP_XNOR = 4'b1011;
  localparam alu_op_t OP_SHL  = 4'b1100;
  localparam alu_op_t OP_SHR  = 4'b1101;
  localparam alu_op_t OP_SRA  = 4'b1110;

  localparam int unsigned IR_LIT_SEL  = 30;
  localparam int unsigned IR_OP_LSB   = 26;
  localparam int unsigned IR_RC_LSB   = 21;
  localparam int unsigned IR_RA_LSB   = 16;
  localparam int unsigned IR_RB_LSB   = 11;
  localparam int unsigned IR_LIT_LSB  = 0;
  localparam int unsigned REG_FIELD_W = 5;
  localparam int unsigned LIT_W       = 16;

endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU.
//   a, b  operands (WIDTH bits)
//   op    opcode (alu_op_t); unknown opcodes give 0
//   y     result, modulo 2^WIDTH; shift amount is b[clog2(WIDTH)-1:0]
module dp_alu
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_SRA:  y = $signed(a) >>> sh;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage (EX -> WB) datapath with register file,
// ALU and literal sign-extension.
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   instruction handshake (transfer = in_valid & in_ready)
//   ir                  [30] lit sel, [29:26] op, [25:21] Rc, [20:16] Ra,
//                       [15:11] Rb, [15:0] literal
//   ext_data, ext_sel   external write data / select it instead of the ALU
//   wb_valid/addr/data  registered write-back, retired at the next edge
//   dbg_addr/dbg_data   unbypassed combinational regfile read
// Build option: DATAPATH_BYPASS_EN forwards wb_data into the operands on a
// RAW hazard; without it the hazarding instruction stalls for one cycle.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             ext_sel,
  output logic             wb_valid,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];

  logic             litSel;
  alu_op_t          op;
  logic [AW-1:0]    raIdx, rbIdx, wbIdx, dbgIdx;
  logic [WIDTH-1:0] lit, regA, regB, opA, opB, aluY, result;
  logic             matchA, matchB, hazard, xfer;
  logic             unusedBits;

  assign litSel = ir[IR_LIT_SEL];
  assign op     = ir[IR_OP_LSB +: 4];
  assign raIdx  = ir[IR_RA_LSB +: AW];
  assign rbIdx  = ir[IR_RB_LSB +: AW];
  assign wbIdx  = wb_addr[AW-1:0];
  assign dbgIdx = dbg_addr[AW-1:0];
  assign lit    = WIDTH'($signed(ir[IR_LIT_LSB +: LIT_W]));

  assign unusedBits = ^{ir[31], ir[IR_RA_LSB +: REG_FIELD_W],
                        ir[IR_RB_LSB +: REG_FIELD_W], dbg_addr, wb_addr};

  // Addresses are truncated to AW bits; slots beyond NREGS read as 0.
  assign regA     = (32'(raIdx)  < NREGS) ? regs[raIdx]  : '0;
  assign regB     = (32'(rbIdx)  < NREGS) ? regs[rbIdx]  : '0;
  assign dbg_data = (32'(dbgIdx) < NREGS) ? regs[dbgIdx] : '0;

  // The regfile is written at the edge after wb_valid rises, so an
  // instruction reading the in-flight Rc would see the stale value.
  assign matchA = wb_valid & (wbIdx == raIdx);
  assign matchB = wb_valid & ~litSel & (wbIdx == rbIdx);
  assign hazard = in_valid & ~ext_sel & (matchA | matchB);

`ifdef DATAPATH_BYPASS_EN
  assign in_ready = 1'b1;
  assign opA      = matchA ? wb_data : regA;
  assign opB      = litSel ? lit : (matchB ? wb_data : regB);
`else
  assign in_ready = ~hazard;
  assign opA      = regA;
  assign opB      = litSel ? lit : regB;
`endif

  assign xfer = in_valid & in_ready;

  dp_alu #(.WIDTH(WIDTH)) uAlu (
    .a  (opA),
    .b  (opB),
    .op (op),
    .y  (aluY)
  );

  assign result = ext_sel ? ext_data : aluY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= xfer;
      if (xfer) begin
        wb_addr <= ir[IR_RC_LSB +: REG_FIELD_W];
        wb_data <= result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_valid && (32'(wbIdx) < NREGS)) begin
      regs[wbIdx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
module tb_pipelined_datapath;
  import datapath_pkg::*;

`ifdef DATAPATH_BYPASS_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 32-register instance
  logic        in_valid = 1'b0, in_ready, ext_sel = 1'b0;
  logic [31:0] ir = '0, ext_data = '0, wb_data, dbg_data;
  logic        wb_valid;
  logic [4:0]  wb_addr, dbg_addr = '0;

  // 16-bit / 8-register instance
  logic        s_in_valid = 1'b0, s_in_ready, s_ext_sel = 1'b0, s_wb_valid;
  logic [31:0] s_ir = '0;
  logic [15:0] s_ext_data = '0, s_wb_data, s_dbg_data;
  logic [4:0]  s_wb_addr, s_dbg_addr = '0;

  pipelined_datapath #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .ext_data(ext_data), .ext_sel(ext_sel), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  pipelined_datapath #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ir(s_ir), .ext_data(s_ext_data), .ext_sel(s_ext_sel), .wb_valid(s_wb_valid),
    .wb_addr(s_wb_addr), .wb_data(s_wb_data), .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wb_t;
  wb_t         sb[$];
  logic [31:0] model [32];

  typedef struct { logic [31:0] ir; logic [31:0] exp; } vec_t;
  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkR(alu_op_t op, logic [4:0] rc, logic [4:0] ra, logic [4:0] rb);
    return {2'b00, op, rc, ra, rb, 11'd0};
  endfunction
  function automatic logic [31:0] mkL(alu_op_t op, logic [4:0] rc, logic [4:0] ra, logic [15:0] l);
    return {2'b01, op, rc, ra, l};
  endfunction
  function automatic logic [31:0] mkE(logic [4:0] rc, logic [4:0] ra);
    return {6'd0, rc, ra, 16'd0};
  endfunction

  // Scoreboard: every observed write-back must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {27'd0, wb_addr}, 32'hFFFFFFFF);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic issue(input logic [31:0] irv, input logic es, input logic [31:0] ed,
                       input logic [31:0] exp, output int stalls);
    wb_t e;
    in_valid = 1'b1; ir = irv; ext_sel = es; ext_data = ed; stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("issue_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    e.addr = irv[25:21]; e.data = exp;
    sb.push_back(e);
    model[irv[25:21]] = exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dbgChk(input logic [4:0] a, input logic [31:0] exp, input string nm);
    dbg_addr = a; #1;
    chk(nm, dbg_data, exp);
  endtask

  task automatic allRegsChk(input string nm);
    for (int i = 0; i < 32; i++) dbgChk(5'(i), model[i], $sformatf("%s_r%0d", nm, i));
  endtask

  task automatic resetWhileBusy(input logic [4:0] rc, input logic [31:0] v, input string nm);
    int st;
    issue(mkE(rc, 5'd0), 1'b1, v, v, st);
    chk({nm, "_wbv_before"}, {31'd0, wb_valid}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    chk({nm, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    chk({nm, "_wbaddr"}, {27'd0, wb_addr}, 32'd0);
    chk({nm, "_wbdata"}, wb_data, 32'd0);
    #1 rst_n = 1'b1;
    idle(2);
    dbgChk(rc, 32'd0, {nm, "_dropped"});
  endtask

  task automatic issue16(input logic [31:0] irv, input logic es, input logic [15:0] ed,
                         input logic [15:0] exp, input string nm);
    int n = 0;
    s_in_valid = 1'b1; s_ir = irv; s_ext_sel = es; s_ext_data = ed;
    @(negedge clk);
    while (!s_in_ready && n < 8) begin n++; @(negedge clk); end
    if (!s_in_ready) chk({nm, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_wbv"}, {31'd0, s_wb_valid}, 32'd1);
    chk({nm, "_wbaddr"}, {27'd0, s_wb_addr}, {27'd0, irv[25:21]});
    chk({nm, "_wbdata"}, {16'd0, s_wb_data}, {16'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    int st;

    for (int i = 0; i < 32; i++) model[i] = '0;
    vecs[0]  = '{mkR(OP_ADD,  5'd11, 5'd4,  5'd7), 32'd11};
    vecs[1]  = '{mkR(OP_SUB,  5'd12, 5'd2,  5'd1), 32'd1};
    vecs[2]  = '{mkR(OP_XNOR, 5'd17, 5'd9,  5'd7), 32'hFFFFFFF1};
    vecs[3]  = '{mkR(OP_SRA,  5'd20, 5'd16, 5'd1), 32'hC0000000};
    vecs[4]  = '{mkL(OP_ADD,  5'd30, 5'd4,  16'hFF00), 32'hFFFFFF04};
    vecs[5]  = '{mkL(OP_SUB,  5'd29, 5'd31, 16'hFF00), 32'h000000FF};
    vecs[6]  = '{mkR(OP_AND,  5'd13, 5'd7,  5'd3), 32'd3};
    vecs[7]  = '{mkR(OP_OR,   5'd14, 5'd4,  5'd3), 32'd7};
    vecs[8]  = '{mkR(OP_XOR,  5'd15, 5'd7,  5'd4), 32'd3};
    vecs[9]  = '{mkR(OP_SHL,  5'd18, 5'd3,  5'd1), 32'd6};
    vecs[10] = '{mkL(OP_SHR,  5'd19, 5'd16, 16'h0004), 32'h08000000};
    vecs[11] = '{mkL(OP_SHL,  5'd21, 5'd1,  16'h0021), 32'd2};
    vecs[12] = '{mkR(4'b0111, 5'd22, 5'd4,  5'd7), 32'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_wbaddr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    idle(1);

    // Reset pulse mid-stream drops the in-flight write
    resetWhileBusy(5'd5, 32'd99, "rst_mid");

    // External writes, back-to-back
    issue(mkE(5'd4, 5'd0), 1'b1, 32'd4, 32'd4, st);
    issue(mkE(5'd7, 5'd0), 1'b1, 32'd7, 32'd7, st);
    issue(mkE(5'd1, 5'd0), 1'b1, 32'd1, 32'd1, st);
    issue(mkE(5'd3, 5'd0), 1'b1, 32'd3, 32'd3, st);
    idle(2);
    allRegsChk("ext");

    issue(mkE(5'd2,  5'd0), 1'b1, 32'd2, 32'd2, st);
    issue(mkE(5'd9,  5'd0), 1'b1, 32'd9, 32'd9, st);
    issue(mkE(5'd16, 5'd0), 1'b1, 32'h80000000, 32'h80000000, st);
    issue(mkE(5'd31, 5'd0), 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
    issue(mkE(5'd22, 5'd0), 1'b1, 32'd55, 32'd55, st);
    idle(2);

    // Spaced ALU vectors
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].ir, 1'b0, 32'd0, vecs[i].exp, st);
      chk($sformatf("vec%0d_stall", i), st, 0);
      idle(1);
      dbgChk(vecs[i].ir[25:21], vecs[i].exp, $sformatf("vec%0d_reg", i));
    end

    // Back-to-back RAW on Ra
    issue(mkL(OP_ADD, 5'd5, 5'd4, 16'd1), 1'b0, 32'd0, 32'd5, st);
    issue(mkL(OP_ADD, 5'd6, 5'd5, 16'd1), 1'b0, 32'd0, 32'd6, st);
    chk("raw_a_stalls", st, EXP_STALL);
    idle(2);
    dbgChk(5'd6, 32'd6, "raw_a_r6");

    // Back-to-back RAW on Rb
    issue(mkR(OP_ADD, 5'd8, 5'd1, 5'd3), 1'b0, 32'd0, 32'd4, st);
    issue(mkR(OP_OR, 5'd10, 5'd3, 5'd8), 1'b0, 32'd0, 32'd7, st);
    chk("raw_b_stalls", st, EXP_STALL);
    idle(2);
    dbgChk(5'd10, 32'd7, "raw_b_r10");

    // Literal bits matching wb_addr in the Rb field, and ext_sel, never hazard
    issue(mkE(5'd24, 5'd0), 1'b1, 32'd10, 32'd10, st);
    issue(mkL(OP_ADD, 5'd26, 5'd1, 16'hC000), 1'b0, 32'd0, 32'hFFFFC001, st);
    chk("lit_nohaz_stalls", st, 0);
    issue(mkE(5'd25, 5'd26), 1'b1, 32'd20, 32'd20, st);
    chk("ext_nohaz_stalls", st, 0);

    // Same Rc back-to-back: later write wins
    issue(mkE(5'd28, 5'd0), 1'b1, 32'd100, 32'd100, st);
    issue(mkE(5'd28, 5'd0), 1'b1, 32'd200, 32'd200, st);
    idle(2);
    allRegsChk("final");

    // Narrow instance: shift amount truncation and Rc aliasing
    issue16(mkE(5'd1, 5'd0), 1'b1, 16'd17, 16'd17, "n_r1");
    issue16(mkE(5'd2, 5'd0), 1'b1, 16'd3, 16'd3, "n_r2");
    issue16(mkR(OP_SHL, 5'd9, 5'd2, 5'd17), 1'b0, 16'd0, 16'd6, "n_shl");
    s_dbg_addr = 5'd1; #1;
    chk("n_alias_r1", {16'd0, s_dbg_data}, 32'd6);
    s_dbg_addr = 5'd9; #1;
    chk("n_alias_r9", {16'd0, s_dbg_data}, 32'd6);
    idle(1);
    issue16(mkL(OP_ADD, 5'd3, 5'd2, 16'hFFFF), 1'b0, 16'd0, 16'd2, "n_lit");

    // Reset while a write is in flight
    resetWhileBusy(5'd27, 32'h1234, "rst_end");
    allRegsChk("post_rst");
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
